// File: rtl/ripple_carry_adder_4_bit.sv
// Registered 4-bit unsigned adder: four full-adder stages rippling LSB to MSB,
// with sum and carry-out captured in a single output register stage.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   logic p;

   assign p  = a ^ b;
   assign s  = p ^ ci;
   assign co = (a & b) | (ci & p);
endmodule

module ripple_carry_adder_4_bit (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] A,
   input  logic [3:0] B,
   output logic [3:0] Sum,
   output logic       C4
);
   localparam int DATA_W = 4;

   logic [DATA_W:0]   carry_p0;
   logic [DATA_W-1:0] sum_p0;
   logic [DATA_W-1:0] sum_p1;
   logic              c4_p1;

   assign carry_p0[0] = 1'b0;

   for (genvar i = 0; i < DATA_W; i++) begin : g_stage
      full_adder u_fa (
         .a  (A[i]),
         .b  (B[i]),
         .ci (carry_p0[i]),
         .s  (sum_p0[i]),
         .co (carry_p0[i+1])
      );
   end

   // p0 -> p1: output register; reset discards any in-flight result
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_p1 <= '0;
         c4_p1  <= 1'b0;
      end else begin
         sum_p1 <= sum_p0;
         c4_p1  <= carry_p0[DATA_W];
      end
   end

   assign Sum = sum_p1;
   assign C4  = c4_p1;
endmodule

// File: tb/tb_ripple_carry_adder_4_bit.sv
// Self-checking bench for ripple_carry_adder_4_bit: directed boundary cases,
// hold behaviour, exhaustive sweep with a mid-stream reset, and random traffic.

module tb_ripple_carry_adder_4_bit;
   logic       clk;
   logic       rst;
   logic [3:0] A;
   logic [3:0] B;
   logic [3:0] Sum;
   logic       C4;

   int errors = 0;
   int checks = 0;

   ripple_carry_adder_4_bit dut (
      .clk (clk),
      .rst (rst),
      .A   (A),
      .B   (B),
      .Sum (Sum),
      .C4  (C4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain unsigned addition widened to 5 bits, zero under reset.
   function automatic logic [4:0] model_add(input logic r, input int a, input int b);
      int total;
      total = r ? 0 : (a + b);
      return total[4:0];
   endfunction

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [4:0] exp;
      A = 4'd9; B = 4'd9; rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         exp = model_add(1'b1, 9, 9);
         checks++;
         if ({C4, Sum} !== exp) begin
            errors++;
            $display("FAIL reset_hold_%0d: got C4=%b Sum=%0d, want C4=%b Sum=%0d",
                     i, C4, Sum, exp[4], exp[3:0]);
         end
      end
      rst = 1'b0;
      tick();
      exp = model_add(1'b0, 9, 9);
      checks++;
      if ({C4, Sum} !== exp || exp !== 5'd18) begin
         errors++;
         $display("FAIL reset_release: got C4=%b Sum=%0d, want C4=1 Sum=2", C4, Sum);
      end
   endtask

   task automatic test_carry_ripple();
      int pairs [2][2] = '{'{15, 1}, '{15, 15}};
      logic [4:0] exp;
      for (int i = 0; i < 2; i++) begin
         A = 4'(pairs[i][0]); B = 4'(pairs[i][1]);
         tick();
         exp = model_add(1'b0, pairs[i][0], pairs[i][1]);
         checks++;
         if ({C4, Sum} !== exp) begin
            errors++;
            $display("FAIL carry_ripple A=%0d B=%0d: got C4=%b Sum=%0d, want C4=%b Sum=%0d",
                     pairs[i][0], pairs[i][1], C4, Sum, exp[4], exp[3:0]);
         end
      end
   endtask

   task automatic test_no_carry();
      int pairs [3][2] = '{'{5, 3}, '{0, 0}, '{10, 5}};
      logic [4:0] exp;
      for (int i = 0; i < 3; i++) begin
         A = 4'(pairs[i][0]); B = 4'(pairs[i][1]);
         tick();
         exp = model_add(1'b0, pairs[i][0], pairs[i][1]);
         checks++;
         if ({C4, Sum} !== exp) begin
            errors++;
            $display("FAIL no_carry A=%0d B=%0d: got C4=%b Sum=%0d, want C4=%b Sum=%0d",
                     pairs[i][0], pairs[i][1], C4, Sum, exp[4], exp[3:0]);
         end
      end
   endtask

   task automatic test_hold();
      logic [4:0] exp;
      A = 4'd2; B = 4'd2;
      tick();
      exp = model_add(1'b0, 2, 2);
      checks++;
      if ({C4, Sum} !== exp) begin
         errors++;
         $display("FAIL hold_load: got C4=%b Sum=%0d, want C4=%b Sum=%0d",
                  C4, Sum, exp[4], exp[3:0]);
      end
      #2;
      A = 4'd7; B = 4'd7;
      #2;
      checks++;
      if ({C4, Sum} !== exp) begin
         errors++;
         $display("FAIL hold_between_edges: got C4=%b Sum=%0d, want C4=%b Sum=%0d",
                  C4, Sum, exp[4], exp[3:0]);
      end
      tick();
      exp = model_add(1'b0, 7, 7);
      checks++;
      if ({C4, Sum} !== exp) begin
         errors++;
         $display("FAIL hold_next_edge: got C4=%b Sum=%0d, want C4=%b Sum=%0d",
                  C4, Sum, exp[4], exp[3:0]);
      end
   endtask

   task automatic test_sweep();
      logic [4:0] exp;
      int         sweep_errors;
      sweep_errors = 0;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            A = 4'(a); B = 4'(b);
            rst = (a == 12 && b == 6);
            tick();
            exp = model_add(rst, a, b);
            rst = 1'b0;
            checks++;
            if ({C4, Sum} !== exp) begin
               errors++;
               sweep_errors++;
               if (sweep_errors <= 10)
                  $display("FAIL sweep A=%0d B=%0d: got C4=%b Sum=%0d, want C4=%b Sum=%0d",
                           a, b, C4, Sum, exp[4], exp[3:0]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [4:0] exp;
      int         a;
      int         b;
      for (int i = 0; i < 64; i++) begin
         a = int'($urandom_range(15, 0));
         b = int'($urandom_range(15, 0));
         A = 4'(a); B = 4'(b);
         rst = ($urandom_range(7, 0) == 0);
         tick();
         exp = model_add(rst, a, b);
         rst = 1'b0;
         checks++;
         if ({C4, Sum} !== exp) begin
            errors++;
            $display("FAIL random_%0d A=%0d B=%0d: got C4=%b Sum=%0d, want C4=%b Sum=%0d",
                     i, a, b, C4, Sum, exp[4], exp[3:0]);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      A   = 4'd0;
      B   = 4'd0;
      test_reset();
      test_carry_ripple();
      test_no_carry();
      test_hold();
      test_sweep();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
